// File: rtl/result_writeback.sv
// Result writeback: captures the four 2x2 convolution results, optionally
// applies ReLU and 2x2 max-pooling, then streams them into the shared data
// SRAM one word per granted cycle.
module result_writeback #(
    parameter bit SIGNED = 1'b1,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] result_baseaddr,
    input  logic              relu_en,
    input  logic              pool_en,
    input  logic [DATA_W-1:0] c11,
    input  logic [DATA_W-1:0] c12,
    input  logic [DATA_W-1:0] c21,
    input  logic [DATA_W-1:0] c22,
    input  logic              mem_gnt,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] d,
    output logic              we,
    output logic              busy,
    output logic              is_done_o
);

    typedef enum logic [1:0] {IDLE, CAPTURE, WRITE, DONE} state_t;

    state_t                   state_q, state_d;
    logic [3:0][DATA_W-1:0]   c_q, c_d;       // slot 0 = c11 ... slot 3 = c22
    logic [3:0][DATA_W-1:0]   buf_q, buf_d;
    logic [3:0][DATA_W-1:0]   relu_w;
    logic [DATA_W-1:0]        max_w;
    logic [DATA_W-1:0]        d_q, d_d;
    logic [ADDR_W-1:0]        base_q, base_d, addr_q, addr_d;
    logic                     relu_q, relu_d, pool_q, pool_d;
    logic [1:0]               idx_q, idx_d;   // slot being written
    logic [1:0]               last_q, last_d; // index of the final write (0 or 3)
    logic                     we_w;

    // Greater-than honouring the configured signedness.
    function automatic logic gt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        if (SIGNED) return $signed(a) > $signed(b);
        else        return a > b;
    endfunction

    // ReLU on each captured word, then max over the four post-ReLU words.
    always_comb begin
        for (int i = 0; i < 4; i++)
            relu_w[i] = (relu_q && SIGNED && c_q[i][DATA_W-1]) ? '0 : c_q[i];
        max_w = relu_w[0];
        for (int i = 1; i < 4; i++)
            if (gt(relu_w[i], max_w)) max_w = relu_w[i];
    end

    // Next-state and datapath updates; we is combinational so a reset
    // cycle can never write.
    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        buf_d   = buf_q;
        base_d  = base_q;
        relu_d  = relu_q;
        pool_d  = pool_q;
        idx_d   = idx_q;
        last_d  = last_q;
        addr_d  = addr_q;
        d_d     = d_q;
        we_w    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    c_d     = {c22, c21, c12, c11};
                    base_d  = result_baseaddr;
                    relu_d  = relu_en;
                    pool_d  = pool_en;
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (pool_q) begin
                    buf_d  = '0;
                    buf_d[0] = max_w;
                    last_d = 2'd0;
                    d_d    = max_w;
                end else begin
                    buf_d  = relu_w;
                    last_d = 2'd3;
                    d_d    = relu_w[0];
                end
                idx_d   = 2'd0;
                addr_d  = base_q;
                state_d = WRITE;
            end
            WRITE: begin
                we_w = mem_gnt & ~rst;
                if (we_w) begin
                    if (idx_q == last_q) begin
                        state_d = DONE;
                    end else begin
                        idx_d  = idx_q + 2'd1;
                        addr_d = addr_q + ADDR_W'(1);
                        d_d    = buf_q[idx_q + 2'd1];
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            c_q     <= '0;
            buf_q   <= '0;
            base_q  <= '0;
            relu_q  <= 1'b0;
            pool_q  <= 1'b0;
            idx_q   <= '0;
            last_q  <= '0;
            addr_q  <= '0;
            d_q     <= '0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            buf_q   <= buf_d;
            base_q  <= base_d;
            relu_q  <= relu_d;
            pool_q  <= pool_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            d_q     <= d_d;
        end
    end

    assign addr      = addr_q;
    assign d         = d_q;
    assign we        = we_w;
    assign busy      = (state_q != IDLE);
    assign is_done_o = (state_q == DONE);

endmodule

// File: tb/tb_result_writeback.sv
// Bench for result_writeback: a signed and an unsigned instance share all
// inputs; expected write streams come from a behavioural model of the
// ReLU / max-pool rules.
module tb_result_writeback;

    logic       clk = 1'b0;
    logic       rst, start, relu_en, pool_en, mem_gnt;
    logic [5:0] base;
    logic [7:0] c11, c12, c21, c22;
    logic [5:0] addr_s, addr_u;
    logic [7:0] d_s, d_u;
    logic       we_s, we_u, busy_s, busy_u, done_s, done_u;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    result_writeback #(.SIGNED(1'b1), .ADDR_W(6), .DATA_W(8)) dut_s (
        .clk(clk), .rst(rst), .start(start), .result_baseaddr(base),
        .relu_en(relu_en), .pool_en(pool_en),
        .c11(c11), .c12(c12), .c21(c21), .c22(c22), .mem_gnt(mem_gnt),
        .addr(addr_s), .d(d_s), .we(we_s), .busy(busy_s), .is_done_o(done_s));

    result_writeback #(.SIGNED(1'b0), .ADDR_W(6), .DATA_W(8)) dut_u (
        .clk(clk), .rst(rst), .start(start), .result_baseaddr(base),
        .relu_en(relu_en), .pool_en(pool_en),
        .c11(c11), .c12(c12), .c21(c21), .c22(c22), .mem_gnt(mem_gnt),
        .addr(addr_u), .d(d_u), .we(we_u), .busy(busy_u), .is_done_o(done_u));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected words to be written: slot 0 = c11 ... slot 3 = c22.
    function automatic int model_words(input logic [3:0][7:0] c, input bit relu, input bit pool,
                                       input bit sgn, output logic [3:0][7:0] w);
        int v[4];
        int m;
        for (int i = 0; i < 4; i++) begin
            v[i] = sgn ? int'($signed(c[i])) : int'(c[i]);
            if (relu && sgn && v[i] < 0) v[i] = 0;
        end
        w = '0;
        if (pool) begin
            m = v[0];
            for (int i = 1; i < 4; i++) if (v[i] > m) m = v[i];
            w[0] = 8'(m);
            return 1;
        end
        for (int i = 0; i < 4; i++) w[i] = 8'(v[i]);
        return 4;
    endfunction

    task automatic scramble();
        {c22, c21, c12, c11} = $urandom;
        base    = 6'($urandom);
        relu_en = 1'($urandom);
        pool_en = 1'($urandom);
        start   = 1'($urandom);
    endtask

    // One full transaction starting in an IDLE cycle. stall[j]=1 drops the
    // grant in write-phase cycle j; rand_gnt picks grants at random instead.
    task automatic run_txn(input logic [5:0] b, input logic [31:0] cw, input bit relu, input bit pool,
                           input logic [15:0] stall, input bit rand_gnt, input int exp_cycles);
        logic [3:0][7:0] c, ws, wu;
        int ns, nu, idx, cyc;
        bit g;
        c  = cw;
        ns = model_words(c, relu, pool, 1'b1, ws);
        nu = model_words(c, relu, pool, 1'b0, wu);
        @(posedge clk); #1;
        start = 1'b1; base = b; {c22, c21, c12, c11} = c;
        relu_en = relu; pool_en = pool; mem_gnt = 1'b1;
        #1;
        check("idle_busy", busy_s, 1'b0);
        check("idle_we", we_s, 1'b0);
        check("idle_done", done_s, 1'b0);
        @(posedge clk); #1;
        scramble();
        #1;
        check("cap_busy_s", busy_s, 1'b1);
        check("cap_busy_u", busy_u, 1'b1);
        check("cap_we", we_s, 1'b0);
        idx = 0; cyc = 0;
        while (idx < ns && cyc < 64) begin
            @(posedge clk); #1;
            g = rand_gnt ? ($urandom_range(0, 2) != 0) : !stall[cyc[3:0]];
            mem_gnt = g;
            scramble();
            #1;
            check("wr_we_s", we_s, g);
            check("wr_we_u", we_u, g);
            check("wr_addr_s", addr_s, 6'(b + 6'(idx)));
            check("wr_addr_u", addr_u, 6'(b + 6'(idx)));
            check("wr_d_s", d_s, ws[idx]);
            check("wr_d_u", d_u, wu[idx]);
            check("wr_busy", busy_s, 1'b1);
            check("wr_done", done_s, 1'b0);
            if (g) idx++;
            cyc++;
        end
        check("wr_finish", idx, ns);
        check("wr_count_u", nu, ns);
        if (exp_cycles >= 0) check("wr_cycles", cyc, exp_cycles);
        @(posedge clk); #1;
        scramble();
        mem_gnt = 1'($urandom);
        #1;
        check("done_s", done_s, 1'b1);
        check("done_u", done_u, 1'b1);
        check("done_we", we_s, 1'b0);
        check("done_busy", busy_s, 1'b1);
        check("done_addr", addr_s, 6'(b + 6'(ns - 1)));
        check("done_d_s", d_s, ws[ns-1]);
        check("done_d_u", d_u, wu[ns-1]);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; relu_en = 1'b0; pool_en = 1'b0; mem_gnt = 1'b1;
        base = '0; c11 = '0; c12 = '0; c21 = '0; c22 = '0;
        @(posedge clk); @(posedge clk); #1;
        start = 1'b1;
        #1;
        check("rst_addr", addr_s, 6'd0);
        check("rst_d", d_s, 8'd0);
        check("rst_we", we_s, 1'b0);
        check("rst_busy", busy_s, 1'b0);
        check("rst_done", done_s, 1'b0);
        rst = 1'b0; start = 1'b0;

        // plain writeback
        run_txn(6'd10, 32'h08070605, 1'b0, 1'b0, 16'h0, 1'b0, 4);
        // ReLU
        run_txn(6'd30, 32'h7FFF1085, 1'b1, 1'b0, 16'h0, 1'b0, 4);
        // max-pool (signed picks 0x12, unsigned picks 0xF0)
        run_txn(6'd20, 32'h801203F0, 1'b0, 1'b1, 16'h0, 1'b0, 1);
        // grant stall across the address wrap
        run_txn(6'd62, 32'hA1B2C3D4, 1'b0, 1'b0, 16'h0006, 1'b0, 6);
        // random back-to-back traffic with random grants
        for (int k = 0; k < 20; k++)
            run_txn(6'($urandom), $urandom, 1'($urandom), 1'($urandom), 16'h0, 1'b1, -1);

        // reset during the second write
        @(posedge clk); #1;
        start = 1'b1; base = 6'd5; {c22, c21, c12, c11} = $urandom;
        relu_en = 1'b0; pool_en = 1'b0; mem_gnt = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        #1;
        check("rstw_first_we", we_s, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rstw_we_s", we_s, 1'b0);
        check("rstw_we_u", we_u, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("rstw_busy", busy_s, 1'b0);
        check("rstw_addr", addr_s, 6'd0);
        check("rstw_d", d_s, 8'd0);
        check("rstw_we", we_s, 1'b0);
        check("rstw_done", done_s, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1; #1;
            check("rstw_nodone", done_s, 1'b0);
            check("rstw_nowe", we_s, 1'b0);
        end

        // start together with reset is dropped
        @(posedge clk); #1;
        start = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; rst = 1'b0;
        #1;
        check("rststart_busy", busy_s, 1'b0);
        @(posedge clk); #1; #1;
        check("rststart_busy2", busy_s, 1'b0);

        // normal operation afterwards
        run_txn(6'd63, 32'h01FE7F80, 1'b1, 1'b0, 16'h0005, 1'b0, 6);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/result_writeback.md
Name: result_writeback

Overview:
- Sits directly downstream of the systolic-mode datapath.
- Captures the four 8-bit convolution results (c11, c12, c21, c22) when the array signals them valid.
- Optionally applies ReLU and 2x2 max-pooling, then writes the results into the shared 64x8 data SRAM.
- Uses a 6-bit address and an 8-bit write port, and waits for a memory grant before each write, because the SRAM port is time-shared with the loaders.

Parameters:
- SIGNED, 1, 1 = results are two's-complement (ReLU and max compare are signed); 0 = unsigned (ReLU has no effect, compare is unsigned).
- ADDR_W, 6, SRAM address width.
- DATA_W, 8, result and SRAM data width.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse: c11..c22 are valid this cycle.
- result_baseaddr  input  ADDR_W  first SRAM address to write.
- relu_en  input  1  clamp negative results to 0 (only when SIGNED=1).
- pool_en  input  1  write only max(c11,c12,c21,c22), as one word.
- c11  input  DATA_W  result (row 1, col 1).
- c12  input  DATA_W  result (row 1, col 2).
- c21  input  DATA_W  result (row 2, col 1).
- c22  input  DATA_W  result (row 2, col 2).
- mem_gnt  input  1  SRAM port granted this cycle.
- addr  output  ADDR_W  SRAM address.
- d  output  DATA_W  SRAM write data.
- we  output  1  SRAM write enable.
- busy  output  1  high in any state other than IDLE.
- is_done_o  output  1  one-cycle pulse after the last write is accepted.

Behaviour:
- Reset values: state=IDLE; all internal regs are 0; addr=0, d=0, we=0, busy=0, is_done_o=0.
- States: IDLE, CAPTURE, WRITE, DONE.
- IDLE:
  - On start=1, register c11..c22, result_baseaddr, relu_en and pool_en at that clock edge, then go to CAPTURE.
  - start is ignored in every other state (no queueing).
- CAPTURE (exactly 1 cycle):
  - Apply ReLU to each word: if relu_en && SIGNED && word[DATA_W-1], the word becomes 0.
  - If pool_en, compute the maximum of the four post-ReLU words into buffer slot 0 and set write count N=1. Otherwise buffer = {c11,c12,c21,c22} in that order, N=4.
  - Reset index to 0, then go to WRITE.
- WRITE:
  - addr = base + index, modulo 2^ADDR_W (wraps 63 -> 0).
  - d = buffer[index].
  - we = mem_gnt & ~rst (combinational).
  - A write is accepted in any cycle where we=1. On acceptance the index increments.
  - When mem_gnt=0, addr and d are held stable and nothing advances.
  - After the accept of index N-1, go to DONE.
- DONE: is_done_o=1 for exactly one cycle, then IDLE. addr and d hold their last values.
- In IDLE, CAPTURE and DONE, we=0.
- Minimum latency with mem_gnt held at 1:
  - start at cycle T, CAPTURE at T+1.
  - Writes at T+2..T+5, done pulse at T+6.
  - With pool_en: one write at T+2, done pulse at T+3.
- Max-pool ties: any equal value is correct, since the output is the value, not a position.
- Reset mid-operation: rst=1 in any state forces we=0 in that same cycle. Next cycle the block is in IDLE with all outputs 0; pending writes are discarded and no done pulse is produced.
- start and rst in the same cycle: rst wins; nothing is captured.
- The c inputs may change after the start cycle without affecting the writes in progress.

Test Plan:
- Plain writeback: base=10, relu_en=0, pool_en=0, c=(5,6,7,8), gnt=1 -> writes (10,5),(11,6),(12,7),(13,8) at T+2..T+5; is_done_o at T+6; busy high T+1..T+6.
- ReLU, SIGNED=1: c=(0x85,0x10,0xFF,0x7F), relu_en=1 -> data written is 0x00,0x10,0x00,0x7F.
- Pooling, SIGNED=1: c=(0xF0,0x03,0x12,0x80), pool_en=1, base=20 -> a single write (20,0x12), then done the next cycle. With SIGNED=0, the same inputs write 0xF0.
- Grant stall and wrap: base=62; mem_gnt low on cycles T+3 and T+4 -> addresses 62,63,0,1 in order; addr/d stable during the stall; done at T+8; no duplicate writes.
- Start while busy: a second start at T+3 with different c values -> ignored; only the first set is written. A start in the cycle after the done pulse is accepted.
- Reset mid-WRITE: rst high during the 2nd write with gnt=1 -> we=0 in that cycle; next cycle is IDLE with all outputs 0; no is_done_o.
